rapq_reg_array: RTL and testbench

//  Register-array priority queue: sorted shift-register of DEPTH entries, smallest key at slot 0.

---
 rtl/rapq_pkg.sv | 15 +
 rtl/rapq_cell.sv | 34 +++
 rtl/rapq_reg_array.sv | 69 ++++++
 tb/tb_rapq_reg_array.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rapq_pkg.sv
// rapq_pkg: shared types and helpers for the register-array priority queue.
package rapq_pkg;
   localparam int KEY_W_DEF  = 16;
   localparam int DATA_W_DEF = 16;
   typedef struct packed {
      logic                  vld;
      logic [KEY_W_DEF-1:0]  key;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;
   typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_PUSHPOP} op_t;
   // Equal keys return 0 so a new entry lands after existing equals.
   function automatic logic goes_before(entry_t e, logic [KEY_W_DEF-1:0] k);
      return !e.vld | (e.key > k);
   endfunction
endpackage

// File: rtl/rapq_cell.sv
// rapq_cell: one queue slot; picks hold / left / right / new entry each cycle.
module rapq_cell
   import rapq_pkg::*;
#(
   parameter bit FIRST = 1'b0
) (
   input  logic   clk,
   input  logic   rst,
   input  op_t    i_op,
   input  entry_t i_own,
   input  entry_t i_left,
   input  entry_t i_right,
   input  entry_t i_new,
   output entry_t o_q
);
   logic   w_b_own, w_b_left, w_b_right;
   entry_t w_nxt;
   assign w_b_own   = goes_before(i_own,   i_new.key);
   assign w_b_left  = goes_before(i_left,  i_new.key);
   assign w_b_right = goes_before(i_right, i_new.key);
   // On push-pop the view is already shifted left, so the insert slot is one lower.
   always_comb begin
      w_nxt = i_own;
      case (i_op)
         OP_PUSH:    w_nxt = !w_b_own ? i_own : !w_b_left ? i_new : i_left;
         OP_POP:     w_nxt = i_right;
         OP_PUSHPOP: w_nxt = !w_b_right ? i_right : (!w_b_own | FIRST) ? i_new : i_own;
         default:    w_nxt = i_own;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) o_q <= '0;
      else     o_q <= w_nxt;
endmodule

// File: rtl/rapq_reg_array.sv
// rapq_reg_array: sorted shift-register priority queue, minimum key served from slot 0.
module rapq_reg_array
   import rapq_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int KEY_W  = KEY_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [KEY_W-1:0]  enq_key,
   input  logic [DATA_W-1:0] enq_data,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [KEY_W-1:0]  deq_key,
   output logic [DATA_W-1:0] deq_data,
   output logic              deq_fire,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);
   // Index 0 and DEPTH+1 are fixed boundary entries around the real slots 1..DEPTH.
   entry_t        w_slot [DEPTH+2];
   entry_t        w_new;
   op_t           w_op;
   logic          w_push, w_pop;
   logic [CW-1:0] r_count;
   logic          r_fire;
   assign w_slot[0]       = '{vld: 1'b1, key: '0, data: '0};
   assign w_slot[DEPTH+1] = '0;
   assign w_new           = '{vld: 1'b1, key: enq_key, data: enq_data};
   assign full      = r_count == CW'(DEPTH);
   assign empty     = r_count == '0;
   assign enq_ready = !full;
   assign deq_valid = !empty;
   assign w_push    = enq_valid & enq_ready;
   assign w_pop     = deq_valid & deq_ready;
   assign w_op      = w_push ? (w_pop ? OP_PUSHPOP : OP_PUSH) : (w_pop ? OP_POP : OP_NOP);
   assign deq_key   = w_slot[1].key;
   assign deq_data  = w_slot[1].data;
   assign deq_fire  = r_fire;
   assign count     = r_count;
   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_cell
         rapq_cell #(.FIRST(i == 0)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .i_op    (w_op),
            .i_own   (w_slot[i+1]),
            .i_left  (w_slot[i]),
            .i_right (w_slot[i+2]),
            .i_new   (w_new),
            .o_q     (w_slot[i+1])
         );
      end
   endgenerate
   always_ff @(posedge clk)
      if (rst) begin
         r_count <= '0;
         r_fire  <= 1'b0;
      end else begin
         r_count <= (w_push & !w_pop) ? r_count + 1'b1 : (w_pop & !w_push) ? r_count - 1'b1 : r_count;
         r_fire  <= w_pop;
      end
endmodule

// File: tb/tb_rapq_reg_array.sv
// tb_rapq_reg_array: directed checks of ordering, FIFO ties, full/empty and reset.
module tb_rapq_reg_array;
   import rapq_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enq_valid = 1'b0, deq_ready = 1'b0;
   logic        enq_ready, deq_valid, deq_fire, full, empty;
   logic [15:0] enq_key = '0, enq_data = '0, deq_key, deq_data;
   logic [4:0]  count;
   int          n_tests = 0, n_fail = 0, n_fire = 0;

   rapq_reg_array dut (
      .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_key(enq_key), .enq_data(enq_data), .deq_valid(deq_valid),
      .deq_ready(deq_ready), .deq_key(deq_key), .deq_data(deq_data),
      .deq_fire(deq_fire), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (!rst && deq_fire) n_fire++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] k, input logic [15:0] d);
      enq_valid = 1'b1; enq_key = k; enq_data = d;
      step();
      enq_valid = 1'b0;
   endtask

   task automatic pop();
      deq_ready = 1'b1;
      step();
      deq_ready = 1'b0;
   endtask

   initial begin
      step(); step();
      rst = 1'b0;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_fire", deq_fire, 0);
      check("rst_key", deq_key, 0);
      // 1: sorting
      push(16'd5, 16'h000A);
      push(16'd2, 16'h000B);
      push(16'd9, 16'h000C);
      check("t1_count3", count, 3);
      check("t1_key0", deq_key, 2);
      check("t1_data0", deq_data, 16'h000B);
      pop();
      check("t1_key1", deq_key, 5);
      check("t1_data1", deq_data, 16'h000A);
      check("t1_fire", deq_fire, 1);
      check("t1_count2", count, 2);
      pop();
      check("t1_key2", deq_key, 9);
      check("t1_data2", deq_data, 16'h000C);
      pop();
      check("t1_count0", count, 0);
      check("t1_empty", empty, 1);
      step();
      check("t1_fires", n_fire, 3);
      // 2: equal keys stay FIFO
      push(16'd7, 16'h0058);
      push(16'd7, 16'h0059);
      check("t2_first", deq_data, 16'h0058);
      pop();
      check("t2_second", deq_data, 16'h0059);
      pop();
      check("t2_empty", empty, 1);
      // 3: full, rejected push with simultaneous pop
      for (int k = 0; k < 16; k++) push(16'(115 - k), 16'(115 - k));
      check("t3_full", full, 1);
      check("t3_enq_ready", enq_ready, 0);
      check("t3_count16", count, 16);
      check("t3_min", deq_key, 100);
      enq_valid = 1'b1; enq_key = 16'd1; enq_data = 16'hDEAD;
      pop();
      enq_valid = 1'b0;
      check("t3_count15", count, 15);
      check("t3_full_drop", full, 0);
      for (int k = 0; k < 15; k++) begin
         check($sformatf("t3_drain%0d", k), deq_key, 101 + k);
         pop();
      end
      check("t3_empty", empty, 1);
      // 4: push-pop inserts into remaining entries
      push(16'd3, 16'h0003);
      push(16'd8, 16'h0008);
      enq_valid = 1'b1; enq_key = 16'd5; enq_data = 16'h0005;
      pop();
      enq_valid = 1'b0;
      check("t4_key", deq_key, 5);
      check("t4_count", count, 2);
      check("t4_fire", deq_fire, 1);
      pop();
      check("t4_next", deq_key, 8);
      pop();
      check("t4_empty", empty, 1);
      step();
      // 5: deq_ready ignored while empty
      n_fire = 0;
      enq_valid = 1'b1; enq_key = 16'd4; enq_data = 16'h0004;
      pop();
      enq_valid = 1'b0;
      check("t5_key", deq_key, 4);
      check("t5_count", count, 1);
      check("t5_fire", deq_fire, 0);
      step();
      check("t5_fires", n_fire, 0);
      // 6: mid-operation reset
      for (int k = 0; k < 5; k++) push(16'(20 + k), 16'(k));
      check("t6_count6", count, 6);
      rst = 1'b1; deq_ready = 1'b1;
      step();
      rst = 1'b0;
      check("t6_empty", empty, 1);
      check("t6_count", count, 0);
      check("t6_key", deq_key, 0);
      check("t6_data", deq_data, 0);
      check("t6_fire", deq_fire, 0);
      step();
      deq_ready = 1'b0;
      check("t6_fire_after", deq_fire, 0);
      check("t6_fires", n_fire, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
